// File: rtl/regfile_port_arbiter.sv
// Arbitrates two writeback requesters and one operand-read requester onto a
// single-ported register file, with RAW hazard blocking and read anti-starvation.
module regfile_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr0_valid,
  output logic        wr0_ready,
  input  logic [4:0]  wr0_addr,
  input  logic [31:0] wr0_data,
  input  logic        wr1_valid,
  output logic        wr1_ready,
  input  logic [4:0]  wr1_addr,
  input  logic [31:0] wr1_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        rsp_valid,
  output logic        rf_write_read_ena,
  output logic [4:0]  rf_write_reg_addr,
  output logic [31:0] rf_data_in,
  output logic [4:0]  rf_read_reg1_addr,
  output logic [4:0]  rf_read_reg2_addr
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic             rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic             wr0_hit;
  logic             wr1_hit;
  logic             hazard;
  logic             starved;
  logic             any_wr;
  logic             gnt_rd;
  logic             gnt_wr0;
  logic             gnt_wr1;

  // Grant selection; x0 destinations never create a RAW dependency.
  always_comb begin
    wr0_hit = wr0_valid && (wr0_addr != '0) && ((wr0_addr == rd_addr1) || (wr0_addr == rd_addr2));
    wr1_hit = wr1_valid && (wr1_addr != '0) && ((wr1_addr == rd_addr1) || (wr1_addr == rd_addr2));
    hazard  = rd_valid && (wr0_hit || wr1_hit);
    starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
    any_wr  = wr0_valid || wr1_valid;
    gnt_rd  = 1'b0;
    gnt_wr0 = 1'b0;
    gnt_wr1 = 1'b0;
    if (!rst) begin
      if (rd_valid && !hazard && (starved || !any_wr)) begin
        gnt_rd = 1'b1;
      end else if (wr0_valid && wr1_valid) begin
        gnt_wr0 = !rr_ptr;
        gnt_wr1 = rr_ptr;
      end else begin
        gnt_wr0 = wr0_valid;
        gnt_wr1 = wr1_valid;
      end
    end
  end

  assign wr0_ready = gnt_wr0;
  assign wr1_ready = gnt_wr1;
  assign rd_ready  = gnt_rd;

  // Idle drives a write of zero to x0 so the file's read data is held.
  always_comb begin
    rf_write_read_ena = 1'b1;
    rf_write_reg_addr = '0;
    rf_data_in        = '0;
    rf_read_reg1_addr = '0;
    rf_read_reg2_addr = '0;
    if (gnt_rd) begin
      rf_write_read_ena = 1'b0;
      rf_read_reg1_addr = rd_addr1;
      rf_read_reg2_addr = rd_addr2;
    end else if (gnt_wr0) begin
      rf_write_reg_addr = ADDR_W'(wr0_addr);
      rf_data_in        = DATA_W'(wr0_data);
    end else if (gnt_wr1) begin
      rf_write_reg_addr = ADDR_W'(wr1_addr);
      rf_data_in        = DATA_W'(wr1_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      rsp_valid <= gnt_rd;
      if (gnt_wr0) begin
        rr_ptr <= 1'b1;
      end else if (gnt_wr1) begin
        rr_ptr <= 1'b0;
      end
      if (gnt_rd || !rd_valid) begin
        starve_cnt <= '0;
      end else if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive stalled read-request cycles after which the read requester gains priority; legal range 1-15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr0_valid / wr0_ready  input / output  1 / 1  writeback requester 0 (ALU) handshake.
REQ-005 wr0_addr / wr0_data  input  5 / 32  requester 0 destination register and write data.
REQ-006 wr1_valid / wr1_ready  input / output  1 / 1  writeback requester 1 (load unit) handshake.
REQ-007 wr1_addr / wr1_data  input  5 / 32  requester 1 destination register and write data.
REQ-008 rd_valid / rd_ready  input / output  1 / 1  operand-read requester (decode) handshake.
REQ-009 rd_addr1 / rd_addr2  input  5 / 5  source register addresses.
REQ-010 rsp_valid  output  1  pulses high when register-file read data is valid.
REQ-011 rf_write_read_ena  output  1  register-file mode: 1 = write, 0 = read.
REQ-012 rf_write_reg_addr / rf_data_in  output  5 / 32  register-file write address and data.
REQ-013 rf_read_reg1_addr / rf_read_reg2_addr  output  5 / 5  register-file read addresses.

Function
REQ-014 The block SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high in the same cycle.
REQ-015 The ready outputs SHALL be combinational functions of the current valid inputs, addresses, and internal state; a ready output SHALL never be high while its valid input is low.
REQ-016 The rf_* outputs SHALL be combinational from the current grant: a write grant drives rf_write_read_ena=1 with the granted address and data; a read grant drives rf_write_read_ena=0 with rd_addr1/rd_addr2.
REQ-017 With no grant, the block SHALL drive rf_write_read_ena=1, rf_write_reg_addr=0 and rf_data_in=0 (a harmless x0 write), so the register file's held read data is preserved.
REQ-018 Write arbitration SHALL be round-robin: rr_ptr names the preferred writer; after any write grant, rr_ptr SHALL point to the other writer; a lone valid writer is granted regardless of rr_ptr.
REQ-019 A RAW hazard exists when rd_valid=1 and any valid writer has a nonzero address equal to rd_addr1 or rd_addr2; during a hazard the read SHALL NOT be granted.
REQ-020 The priority order SHALL be: (a) read, if starve_cnt==STARVE_LIMIT and there is no hazard; (b) writes per REQ-018; (c) read, if no writer is valid.
REQ-021 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, each cycle rd_valid=1 and rd_ready=0, and SHALL clear on a read grant or when rd_valid=0.
REQ-022 rsp_valid SHALL be 1 exactly in the cycle after a read grant; this gives a fixed read latency of one cycle, and the consumer samples the register-file read data in that cycle.
REQ-023 A write to address 0 SHALL be accepted and forwarded unchanged; x0 protection belongs to the register file.
REQ-024 Back-to-back grants of any kind SHALL be allowed with no bubble cycles.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force rr_ptr=writer 0, starve_cnt=0, and rsp_valid=0; the ready outputs SHALL be 0 and the rf_* outputs SHALL be the idle values of REQ-017.
REQ-026 A read granted in the cycle rst asserts SHALL produce no rsp_valid pulse; after rst deasserts, arbitration SHALL resume on the first rising edge.

Verification
REQ-027 wr0 and wr1 both valid continuously (addrs 3 and 4), rd idle -> grants alternate wr0, wr1, wr0, wr1; rf_write_reg_addr reads 3, 4, 3, 4; no idle cycles.
REQ-028 rd_valid with addrs 5/6 and no writers -> rd_ready=1 in cycle N, rf_write_read_ena=0 in cycle N, rsp_valid=1 in cycle N+1 only.
REQ-029 wr0 always valid (addr 7), rd always valid (addrs 1/2), STARVE_LIMIT=4 -> read stalls 4 cycles, then is granted in the 5th; starve_cnt then returns to 0.
REQ-030 wr1 valid with addr 9 and rd_addr2=9 while starve_cnt==STARVE_LIMIT -> wr1 granted first, read granted the next cycle; a writer with addr 0 matching rd_addr1=0 causes no stall.
REQ-031 rst pulsed asynchronously mid-burst, in the same cycle as a read grant -> rsp_valid stays 0, ready outputs drop immediately, rf_write_read_ena=1 with address 0, and wr0 is granted first after release.
REQ-032 No requests for 10 cycles -> rf_write_read_ena=1, rf_write_reg_addr=0, rf_data_in=0 every cycle, and the register-file read outputs remain unchanged.
